// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: states and constants shared by uart_tx_arbiter; UART_ARB_HEADER_EN adds the HEADER state
package uart_arb_pkg;
  localparam int BYTE_W = 8;
  localparam logic [7:0] HDR_BASE = 8'hA0;
`ifdef UART_ARB_HEADER_EN
  typedef enum logic [2:0] {IDLE, GRANT, START, WAIT, NEXT, HEADER} state_t;
`else
  typedef enum logic [2:0] {IDLE, GRANT, START, WAIT, NEXT} state_t;
`endif
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester bus plus transmitter handshake of uart_tx_arbiter
interface uart_tx_arbiter_if #(parameter int NREQ = 2, parameter int WORD_W = 32);
  logic [NREQ-1:0] req;
  logic [NREQ*WORD_W-1:0] req_data;
  logic [NREQ-1:0] done;
  logic [7:0] tx_data;
  logic tx_start;
  logic tx_done;
  logic busy;
  modport master (output req, req_data, tx_done, input done, tx_data, tx_start, busy);
  modport slave (input req, req_data, tx_done, output done, tx_data, tx_start, busy);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester after the last granted index
module rr_arbiter #(parameter int NREQ = 2) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_last,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_idx
);
  // scan farthest to nearest so the nearest requester after i_last overwrites the rest
  always_comb begin
    o_grant = '0;
    o_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (i_req[(int'(i_last) + k) % NREQ]) begin
        o_grant = '0;
        o_grant[(int'(i_last) + k) % NREQ] = 1'b1;
        o_idx = ($clog2(NREQ))'((int'(i_last) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter serializing request words MSB-first into a UART transmitter
// Define UART_ARB_HEADER_EN to prefix each word with the byte HDR_BASE | grant index.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(parameter int NREQ = 2, parameter int WORD_W = 32) (
  input logic clk,
  input logic reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NREQ);
  localparam int NBYTES = WORD_W / BYTE_W;
  localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  state_t r_state, w_next;
  logic [WORD_W-1:0] r_word;
  logic [CNT_W-1:0] r_cnt;
  logic [NREQ-1:0] r_grant, w_grant;
  logic [IDX_W-1:0] r_idx, r_ptr, w_idx;
  logic w_hdr, w_last;
  rr_arbiter #(.NREQ(NREQ)) u_rr (.i_req(bus.req), .i_last(r_ptr), .o_grant(w_grant), .o_idx(w_idx));
`ifdef UART_ARB_HEADER_EN
  logic r_hdr;
  assign w_hdr = r_hdr;
  // header flag: raised on grant, dropped once the header byte is acknowledged
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_hdr <= 1'b0;
    else if (r_state == GRANT) r_hdr <= |bus.req;
    else if (r_state == NEXT) r_hdr <= 1'b0;
`else
  assign w_hdr = 1'b0;
`endif
  assign w_last = (r_cnt == '0) && !w_hdr;
  assign bus.busy = r_state != IDLE;
  assign bus.tx_data = w_hdr ? (HDR_BASE | 8'(r_idx)) : r_word[WORD_W-1 -: BYTE_W];
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  // next state, tx_start and done pulses
  always_comb begin
    w_next = r_state;
    bus.tx_start = 1'b0;
    bus.done = '0;
    case (r_state)
      IDLE: w_next = |bus.req ? GRANT : IDLE;
`ifdef UART_ARB_HEADER_EN
      GRANT: w_next = |bus.req ? HEADER : IDLE;
      HEADER: begin
        bus.tx_start = 1'b1;
        w_next = WAIT;
      end
`else
      GRANT: w_next = |bus.req ? START : IDLE;
`endif
      START: begin
        bus.tx_start = 1'b1;
        w_next = WAIT;
      end
      WAIT: w_next = bus.tx_done ? NEXT : WAIT;
      NEXT: begin
        w_next = w_last ? IDLE : START;
        bus.done = w_last ? r_grant : '0;
      end
      default: w_next = IDLE;
    endcase
  end
  // word latch on grant, byte shift per acknowledged byte, pointer update on completion
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_word <= '0;
      r_cnt <= '0;
      r_grant <= '0;
      r_idx <= '0;
      r_ptr <= IDX_W'(NREQ - 1);
    end else if (r_state == GRANT) begin
      r_word <= bus.req_data[w_idx*WORD_W +: WORD_W];
      r_cnt <= CNT_W'(NBYTES - 1);
      r_grant <= w_grant;
      r_idx <= w_idx;
    end else if (r_state == NEXT && !w_hdr) begin
      if (w_last) r_ptr <= r_idx;
      else begin
        r_cnt <= r_cnt - 1'b1;
        r_word <= r_word << BYTE_W;
      end
    end
endmodule
